// File: rtl/axis_tid_demux_n_pkg.sv
// ----------------------------------------------------------------------------
// axis_tid_demux_n_pkg
// Purpose : shared types and helpers for the AXI-Stream TID demultiplexer.
// Contents: pkt_state_e  - packet-tracking states (IDLE / ROUTE / DROP)
//           tid_in_range - true when a destination id addresses a real output
// ----------------------------------------------------------------------------
package axis_tid_demux_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the first beat of a packet
    ST_ROUTE = 2'd1,  // inside a packet headed for a valid output
    ST_DROP  = 2'd2   // inside a packet whose id has no output
  } pkt_state_e;

  // Ids are zero-extended to 32 bits by the caller so one helper serves any ID_W.
  function automatic logic tid_in_range(input logic [31:0] tid, input int unsigned num_m);
    return tid < num_m;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// ----------------------------------------------------------------------------
// axis_skid_reg
// Purpose : two-entry (main + skid) register slice for a valid/ready stream.
//           Both directions are fully registered: s_ready is a flop that
//           means "skid entry empty", m_valid/m_data come from the main entry.
// Ports   : clk, rstn            - clock, asynchronous active-low reset
//           s_valid/s_ready/s_data - upstream handshake and payload
//           m_valid/m_ready/m_data - downstream handshake and payload
// ----------------------------------------------------------------------------
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic         r_ready;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;

  logic w_push;
  logic w_pop;
  logic w_main_valid_next;
  logic w_skid_valid_next;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_from_in;

  assign w_push = s_valid && r_ready;
  assign w_pop  = r_main_valid && m_ready;

  // r_ready is low whenever the skid entry holds data, so a push never
  // coincides with a skid-to-main transfer.
  always_comb begin
    w_main_valid_next = r_main_valid;
    w_skid_valid_next = r_skid_valid;
    w_main_from_in    = 1'b0;
    w_main_from_skid  = 1'b0;
    w_skid_from_in    = 1'b0;
    if (w_pop) begin
      if (r_skid_valid) begin
        w_main_from_skid  = 1'b1;
        w_skid_valid_next = 1'b0;
      end else if (w_push) begin
        w_main_from_in = 1'b1;
      end else begin
        w_main_valid_next = 1'b0;
      end
    end else if (w_push) begin
      if (!r_main_valid) begin
        w_main_from_in    = 1'b1;
        w_main_valid_next = 1'b1;
      end else begin
        w_skid_from_in    = 1'b1;
        w_skid_valid_next = 1'b1;
      end
    end
  end

  // r_ready is held low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_ready      <= !w_skid_valid_next;
    end
  end

  // Payload needs no reset: it is only observed while the matching valid is set.
  always_ff @(posedge clk) begin
    if (w_main_from_skid) begin
      r_main_data <= r_skid_data;
    end else if (w_main_from_in) begin
      r_main_data <= s_data;
    end
    if (w_skid_from_in) begin
      r_skid_data <= s_data;
    end
  end

  assign s_ready = r_ready;
  assign m_valid = r_main_valid;
  assign m_data  = r_main_data;

endmodule

// File: rtl/axis_tid_demux_n.sv
// ----------------------------------------------------------------------------
// axis_tid_demux_n
// Purpose : routes whole AXI-Stream packets to one of NUM_M outputs selected by
//           the tid of the packet's first beat. Packets whose tid has no output
//           are consumed and counted in drop_cnt (saturating).
// Ports   : clk, rstn                       - clock, async active-low reset
//           s_tvalid/s_tready/s_tdata/s_tid/s_tlast - slave stream
//           m_tvalid[NUM_M]/m_tready[NUM_M]  - per-output handshake
//           m_tdata/m_tlast                  - payload shared by all outputs
//           drop_cnt                         - dropped-packet counter
// ----------------------------------------------------------------------------
module axis_tid_demux_n
  import axis_tid_demux_n_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 2,
  parameter int NUM_M      = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [ID_W-1:0]       s_tid,
  input  logic                  s_tlast,
  output logic [NUM_M-1:0]      m_tvalid,
  input  logic [NUM_M-1:0]      m_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic                  m_tlast,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // Buffered entry layout: {tlast, dest, tdata}
  localparam int PW = DATA_W + 1 + ID_W;

  generate
    if (NUM_M < 2 || NUM_M > (1 << ID_W)) begin : g_bad_num_m
      $error("axis_tid_demux_n: NUM_M must lie in 2..2**ID_W");
    end
    if (ID_W < 1 || ID_W > 8) begin : g_bad_id_w
      $error("axis_tid_demux_n: ID_W must lie in 1..8");
    end
  endgenerate

  pkt_state_e            r_state;
  logic [ID_W-1:0]       r_dest;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic            w_first;
  logic [ID_W-1:0] w_dest;
  logic            w_dest_ok;
  logic            w_s_ready;
  logic            w_accept;
  logic [PW-1:0]   w_skid_in;
  logic [PW-1:0]   w_main;
  logic            w_main_valid;
  logic [ID_W-1:0] w_main_dest;
  logic            w_main_ready;

  // The destination comes from s_tid only on a packet's first beat; later
  // beats reuse the latched value so their tid is ignored.
  assign w_first   = (r_state == ST_IDLE);
  assign w_dest    = w_first ? s_tid : r_dest;
  assign w_dest_ok = w_first ? tid_in_range(32'(s_tid), NUM_M) : (r_state == ST_ROUTE);

  // Dropped beats are still accepted whenever the skid entry is empty, but
  // they never enter the buffer.
  assign s_tready  = w_s_ready;
  assign w_accept  = s_tvalid && w_s_ready;
  assign w_skid_in = {s_tlast, w_dest, s_tdata};

  axis_skid_reg #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_tvalid && w_dest_ok),
    .s_ready (w_s_ready),
    .s_data  (w_skid_in),
    .m_valid (w_main_valid),
    .m_ready (w_main_ready),
    .m_data  (w_main)
  );

  assign m_tdata     = w_main[DATA_W-1:0];
  assign w_main_dest = w_main[DATA_W +: ID_W];
  assign m_tlast     = w_main[PW-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_valid
      assign m_tvalid[gi] = w_main_valid && (w_main_dest == ID_W'(gi));
    end
  endgenerate

  // Only the addressed output's ready can retire the main entry.
  assign w_main_ready = |(m_tvalid & m_tready);

  // Packet tracking and drop counting. A single-beat packet leaves the
  // state in IDLE because its first beat is also its last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_dest     <= '0;
      r_drop_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!s_tlast) begin
            r_state <= w_dest_ok ? ST_ROUTE : ST_DROP;
            r_dest  <= s_tid;
          end
        end
        default: begin
          if (s_tlast) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
      if (!w_dest_ok && s_tlast && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_axis_tid_demux_n.sv
`timescale 1ns/1ps
module tb_axis_tid_demux_n;

  localparam int DATA_W     = 64;
  localparam int ID_W       = 2;
  localparam int NUM_M      = 3;
  localparam int DROP_CNT_W = 2;
  localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  s_tvalid = 1'b0;
  logic                  s_tready;
  logic [DATA_W-1:0]     s_tdata = '0;
  logic [ID_W-1:0]       s_tid = '0;
  logic                  s_tlast = 1'b0;
  logic [NUM_M-1:0]      m_tvalid;
  logic [NUM_M-1:0]      m_tready = '1;
  logic [DATA_W-1:0]     m_tdata;
  logic                  m_tlast;
  logic [DROP_CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  axis_tid_demux_n #(
    .DATA_W     (DATA_W),
    .ID_W       (ID_W),
    .NUM_M      (NUM_M),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tid    (s_tid),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .drop_cnt (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the output stage is a queue of at most two beats that
  // were accepted for a real output and not yet taken by their consumer.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
    int                dest;
  } beat_t;

  beat_t q[$];
  int    exp_drop  = 0;
  logic  exp_ready = 1'b0;
  logic  in_pkt    = 1'b0;
  int    cur_dest  = 0;
  logic  rdy_rand  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare on the falling edge, then predict the next rising edge.
  always @(negedge clk) begin : cmp_proc
    logic [NUM_M-1:0] ev;
    logic             pop;
    logic             acc;
    int               dest;
    if (!rstn) begin
      q.delete();
      exp_drop  = 0;
      exp_ready = 1'b0;
      in_pkt    = 1'b0;
      cur_dest  = 0;
    end
    ev = '0;
    if (q.size() > 0) ev[q[0].dest] = 1'b1;
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    chk("s_tready", 64'(s_tready), 64'(exp_ready));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    if (q.size() > 0) begin
      chk("m_tdata", m_tdata, q[0].d);
      chk("m_tlast", 64'(m_tlast), 64'(q[0].l));
    end
    if (rstn) begin
      pop = (q.size() > 0) && m_tready[q[0].dest];
      acc = s_tvalid && exp_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        dest = in_pkt ? cur_dest : int'(s_tid);
        if (dest < NUM_M) q.push_back('{d: s_tdata, l: s_tlast, dest: dest});
        else if (s_tlast && exp_drop < DROP_MAX) exp_drop++;
        in_pkt   = !s_tlast;
        cur_dest = dest;
      end
      exp_ready = (q.size() < 2);
    end
  end

  // Random output back-pressure, each ready high about 3 cycles in 4.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        for (int k = 0; k < NUM_M; k++) m_tready[k] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Present one beat and hold it until the handshake completes (bounded).
  task automatic send_beat(input logic [DATA_W-1:0] d, input int tid, input logic last);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tid    = ID_W'(tid);
    s_tlast  = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_accept_timeout", 64'(acc), 64'd1);
    s_tvalid = 1'b0;
  endtask

  // Back-to-back packet with every beat accepted on first offer; pins the
  // output pattern one cycle after each accept.
  task automatic directed_pkt(input int tf, input int tr, input int n, input logic [NUM_M-1:0] ev);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom};
        s_tid    = ID_W'((i == 0) ? tf : tr);
        s_tlast  = (i == n - 1);
      end else begin
        s_tvalid = 1'b0;
      end
      @(negedge clk);
      chk("dir_s_tready", 64'(s_tready), 64'd1);
      if (i > 0) begin
        chk("dir_m_tvalid", 64'(m_tvalid), 64'(ev));
        if (ev != '0) chk("dir_m_tlast", 64'(m_tlast), 64'(i == n));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  localparam int EXP_DROP [5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset state and release.
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_edge", 64'(s_tready), 64'd1);
    @(posedge clk); #1;

    // 4-beat packet to output 2, then a tid=1 packet whose later tids say 0.
    directed_pkt(2, 2, 4, 3'b100);
    directed_pkt(1, 0, 4, 3'b010);

    // 3-beat packet to a missing output: nothing emitted, one drop.
    directed_pkt(3, 3, 3, 3'b000);
    @(negedge clk);
    chk("drop_after_tlast", 64'(drop_cnt), 64'd1);
    @(posedge clk); #1;

    // Output 2 stalled for 5 cycles during an 8-beat stream.
    m_tready = 3'b011;
    fork
      begin
        for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom}, 2, b == 7);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_s_tready_low", 64'(s_tready), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        m_tready = 3'b111;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Fill both entries, then reset in the middle of the packet.
    m_tready = 3'b000;
    send_beat({$urandom, $urandom}, 1, 1'b0);
    send_beat({$urandom, $urandom}, 0, 1'b0);
    @(negedge clk);
    chk("full_s_tready_low", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_tready = 3'b111;
    @(posedge clk); #1;
    directed_pkt(0, 2, 2, 3'b001);

    // Five invalid single-beat packets against a 2-bit saturating counter.
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom};
        s_tid    = 2'd3;
        s_tlast  = 1'b1;
      end else begin
        s_tvalid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) chk("sat_drop_cnt", 64'(drop_cnt), 64'(EXP_DROP[i-1]));
      @(posedge clk); #1;
    end

    // Randomised packets, ids, gaps and back-pressure.
    rdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int tid;
      int len;
      tid = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_tvalid = 1'b0;
          @(posedge clk); #1;
        end
        send_beat({$urandom, $urandom}, (b == 0) ? tid : $urandom_range(0, 3), b == len - 1);
      end
    end
    rdy_rand = 1'b0;
    @(posedge clk); #2;
    m_tready = '1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("drain_s_tready", 64'(s_tready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_tid_demux_n.md
AXIS_TID_DEMUX_N -- requirements
Module: axis_tid_demux_n

Interface
REQ-001 DATA_W, 64, width of tdata in bits (8..1024).
REQ-002 ID_W, 2, width of s_tid in bits (1..8).
REQ-003 NUM_M, 4, number of master outputs (2..2^ID_W).
REQ-004 DROP_CNT_W, 16, width of the drop counter.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 s_tvalid  in  1  slave beat valid.
REQ-008 s_tready  out  1  slave beat ready.
REQ-009 s_tdata  in  DATA_W  slave payload.
REQ-010 s_tid  in  ID_W  destination select, sampled on first beat of a packet.
REQ-011 s_tlast  in  1  end of packet.
REQ-012 m_tvalid  out  NUM_M  per-output valid, at most one bit set.
REQ-013 m_tready  in  NUM_M  per-output ready.
REQ-014 m_tdata  out  DATA_W  payload shared by all outputs.
REQ-015 m_tlast  out  1  end of packet shared by all outputs.
REQ-016 drop_cnt  out  DROP_CNT_W  packets discarded for out-of-range tid.

Function
REQ-017 The block SHALL route whole packets: destination latched from s_tid on the first accepted beat of a packet, held until the beat with s_tlast is accepted; s_tid on later beats SHALL be ignored.
REQ-018 Beat accepted at slave = s_tvalid && s_tready; beat accepted at output k = m_tvalid[k] && m_tready[k].
REQ-019 Latency SHALL be exactly 1 cycle from slave acceptance to m_tvalid assertion when the output stage is empty.
REQ-020 Output stage SHALL be a 2-entry skid buffer (main + skid) holding {tdata, tlast, dest}; s_tready SHALL be a register equal to "skid entry empty".
REQ-021 With selected m_tready held high, throughput SHALL be one beat per cycle with no bubbles, including across packet boundaries to different destinations.
REQ-022 m_tvalid[k] SHALL be 1 only when the main entry is valid and its dest == k; m_tdata/m_tlast SHALL reflect the main entry and be stable while m_tvalid is high and m_tready low.
REQ-023 When output stalls, the next slave beat SHALL land in the skid entry and s_tready SHALL drop the following cycle; on the stalled beat's acceptance, skid SHALL move to main.
REQ-024 If latched tid >= NUM_M, the packet SHALL be consumed at one beat per cycle (s_tready tracks skid-empty), never written to the output stage, and drop_cnt SHALL increment by 1 when its tlast beat is accepted.
REQ-025 drop_cnt SHALL saturate at 2^DROP_CNT_W-1.
REQ-026 Packet-state FSM: IDLE (awaiting first beat) -> ROUTE (valid dest) or DROP (invalid dest) on accepted non-last first beat; ROUTE/DROP -> IDLE on accepted tlast beat; single-beat packet (first beat with tlast) SHALL stay in IDLE.
REQ-027 No combinational path from any m_tready to s_tready, nor from s_tvalid to any m_tvalid.

Reset
REQ-028 While rstn low: m_tvalid = 0, s_tready = 0, drop_cnt = 0, FSM = IDLE, both skid entries invalid; m_tdata/m_tlast undefined-but-stable.
REQ-029 s_tready SHALL rise on the first clk edge after rstn deasserts.
REQ-030 Reset mid-packet SHALL discard buffered beats; the first beat after reset SHALL be treated as a packet start.

Structure
REQ-031 The skid buffer SHALL be a sub-module axis_skid_reg, parametrised on payload width (DATA_W+1+ID_W).
REQ-032 No shared package is required; NUM_M range check SHALL be an elaboration-time assertion.

Verification
REQ-033 Reset release, NUM_M=4, all m_tready=1; 4-beat packet tid=2 -> m_tvalid=4'b0100 one cycle after each accept, 4 consecutive cycles, m_tlast on 4th.
REQ-034 tid changed to 0 on beats 2..4 of a tid=1 packet -> all 4 beats appear on output 1 only.
REQ-035 m_tready[3]=0 for 5 cycles during tid=3 stream -> s_tready low after 2 beats buffered, no beat lost or duplicated, order preserved.
REQ-036 ID_W=2, NUM_M=3, 3-beat packet tid=3 -> m_tvalid stays 0, s_tready high throughout, drop_cnt 0->1 after tlast.
REQ-037 DROP_CNT_W=2, five invalid single-beat packets -> drop_cnt reads 1,2,3,3,3.
REQ-038 rstn pulsed low mid-packet with skid full -> m_tvalid=0 immediately, drop_cnt=0; next beat's tid sets the destination.
